// File: rtl/bitop16_pkg.sv
// Shared types for the bitop16 datapath and its round-robin arbiter.
// Holds the opcode encoding, the arbiter FSM state type and the bitwise
// evaluation function used by the combinational datapath.
package bitop16_pkg;

    localparam int DATA_W = 16;

    // Opcode encoding shared by every requester of the logic unit
    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } bitop_e;

    // IDLE: no result held; RESP: a result is waiting for the consumer
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_e;

    // Pure bitwise evaluation; no carries cross bit positions
    function automatic logic [DATA_W-1:0] bitop_eval(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input bitop_e            op
    );
        logic [DATA_W-1:0] res;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NAND: res = ~(a & b);
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bitop16.sv
// Shared 16-bit bitwise logic unit (AND / OR / XOR / NAND).
// Purely combinational: the arbiter registers the result itself.
module bitop16
    import bitop16_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  bitop_e            op_i,
    output logic [DATA_W-1:0] result_o
);

    // Evaluate the selected bitwise operation on the muxed operands
    always_comb begin
        result_o = bitop_eval(a_i, b_i, op_i);
    end

endmodule

// File: rtl/bitop16_arbiter.sv
// Round-robin arbiter and sequencer sharing one bitop16 unit among
// NUM_REQ requesters. One request is accepted per cycle; its result is
// registered and returned with the requester index over a valid/ready
// response handshake.
// Optional feature macro: BITOP16_ARB_LOCK_EN adds the req_lock_i port,
// which lets a granted requester keep round-robin priority for a burst.
module bitop16_arbiter
    import bitop16_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [DATA_W*NUM_REQ-1:0] req_a_i,
    input  logic [DATA_W*NUM_REQ-1:0] req_b_i,
    input  logic [2*NUM_REQ-1:0]      req_op_i,
`ifdef BITOP16_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock_i,
`endif
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DATA_W-1:0]         rsp_data_o,
    output logic [ID_W-1:0]           rsp_id_o
);

    arb_state_e        state_q;
    logic [ID_W-1:0]   rrPtr_q;
    logic [ID_W-1:0]   rrPtr_d;
    logic              rspValid_q;
    logic [DATA_W-1:0] rspData_q;
    logic [ID_W-1:0]   rspId_q;

    logic [NUM_REQ-1:0] validRot;
    logic               candFound;
    logic [ID_W-1:0]    candOff;
    logic [ID_W:0]      candSum;
    logic [ID_W-1:0]    candId;
    logic [ID_W:0]      nextSum;
    logic [ID_W-1:0]    nextPtr;

    logic [DATA_W-1:0]  candA;
    logic [DATA_W-1:0]  candB;
    bitop_e             candOp;
    logic [DATA_W-1:0]  candResult;

    logic               accEn;
    logic               handshake;
    logic [NUM_REQ-1:0] reqReady;

    // Rotate the valid vector so bit 0 is the requester at rr_ptr, then
    // pick the lowest set bit; that offset plus rr_ptr (mod NUM_REQ) is
    // the grant candidate for this cycle
    always_comb begin
        validRot  = NUM_REQ'({req_valid_i, req_valid_i} >> rrPtr_q);
        candFound = 1'b0;
        candOff   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (validRot[j]) begin
                candFound = 1'b1;
                candOff   = ID_W'(j);
            end
        end
        candSum = {1'b0, rrPtr_q} + {1'b0, candOff};
        if (candSum >= (ID_W+1)'(NUM_REQ)) begin
            candSum = candSum - (ID_W+1)'(NUM_REQ);
        end
        candId = candSum[ID_W-1:0];
    end

    // Pointer value after a normal grant: one past the candidate, wrapping
    // from NUM_REQ-1 back to 0
    always_comb begin
        nextSum = {1'b0, candId} + (ID_W+1)'(1);
        if (nextSum == (ID_W+1)'(NUM_REQ)) begin
            nextPtr = '0;
        end else begin
            nextPtr = nextSum[ID_W-1:0];
        end
    end

`ifdef BITOP16_ARB_LOCK_EN
    logic lockHit;

    // A locked grant keeps the pointer on the candidate so it wins again;
    // the first unlocked grant releases it by advancing normally
    always_comb begin
        lockHit = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (candId == ID_W'(i)) begin
                lockHit = req_lock_i[i];
            end
        end
        rrPtr_d = lockHit ? candId : nextPtr;
    end
`else
    // Without the lock feature the pointer always moves past the grantee
    always_comb begin
        rrPtr_d = nextPtr;
    end
`endif

    // Select the candidate's operands and opcode for the shared datapath
    always_comb begin
        candA  = '0;
        candB  = '0;
        candOp = OP_AND;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (candId == ID_W'(i)) begin
                candA  = req_a_i[DATA_W*i +: DATA_W];
                candB  = req_b_i[DATA_W*i +: DATA_W];
                candOp = bitop_e'(req_op_i[2*i +: 2]);
            end
        end
    end

    bitop16 u_bitop16 (
        .a_i      (candA),
        .b_i      (candB),
        .op_i     (candOp),
        .result_o (candResult)
    );

    // Accept a new request whenever the result register is empty or is
    // being drained this cycle; ready is forced low while reset is held
    always_comb begin
        accEn     = (state_q == IDLE) || ((state_q == RESP) && rsp_ready_i);
        handshake = accEn && candFound;
        reqReady  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst_n && handshake && (candId == ID_W'(i))) begin
                reqReady[i] = 1'b1;
            end
        end
    end

    // Arbiter FSM: a handshake loads a fresh result from either state; a
    // drained result with nothing new pending returns to IDLE while data
    // and id keep their last values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rrPtr_q    <= '0;
            rspValid_q <= 1'b0;
            rspData_q  <= '0;
            rspId_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        state_q    <= RESP;
                        rspValid_q <= 1'b1;
                        rspData_q  <= candResult;
                        rspId_q    <= candId;
                        rrPtr_q    <= rrPtr_d;
                    end
                end
                RESP: begin
                    if (handshake) begin
                        state_q    <= RESP;
                        rspValid_q <= 1'b1;
                        rspData_q  <= candResult;
                        rspId_q    <= candId;
                        rrPtr_q    <= rrPtr_d;
                    end else if (rsp_ready_i) begin
                        state_q    <= IDLE;
                        rspValid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    rspValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = reqReady;
    assign rsp_valid_o = rspValid_q;
    assign rsp_data_o  = rspData_q;
    assign rsp_id_o    = rspId_q;

endmodule

// File: tb/tb_bitop16_arbiter.sv
// Directed testbench for bitop16_arbiter with NUM_REQ=4.
// Inputs change 1ns after the rising edge; registered outputs are sampled
// 1ns after the edge and combinational ready 1ns after inputs change.
// The lock scenario is built only when BITOP16_ARB_LOCK_EN is defined.
module tb_bitop16_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   reqValid;
    logic [NUM_REQ-1:0]   reqReady;
    logic [16*NUM_REQ-1:0] reqA;
    logic [16*NUM_REQ-1:0] reqB;
    logic [2*NUM_REQ-1:0] reqOp;
`ifdef BITOP16_ARB_LOCK_EN
    logic [NUM_REQ-1:0]   reqLock;
`endif
    logic                 rspValid;
    logic                 rspReady;
    logic [15:0]          rspData;
    logic [ID_W-1:0]      rspId;

    int compared   = 0;
    int mismatched = 0;

    bitop16_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (reqValid),
        .req_ready_o (reqReady),
        .req_a_i     (reqA),
        .req_b_i     (reqB),
        .req_op_i    (reqOp),
`ifdef BITOP16_ARB_LOCK_EN
        .req_lock_i  (reqLock),
`endif
        .rsp_valid_o (rspValid),
        .rsp_ready_i (rspReady),
        .rsp_data_o  (rspData),
        .rsp_id_o    (rspId)
    );

    // Free-running 10ns clock
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] op);
        reqA[16*i +: 16] = a;
        reqB[16*i +: 16] = b;
        reqOp[2*i +: 2]  = op;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        reqValid = '0;
        reqA     = '0;
        reqB     = '0;
        reqOp    = '0;
        rspReady = 1'b0;
`ifdef BITOP16_ARB_LOCK_EN
        reqLock  = '0;
`endif
        #12;
        compared++;
        if (rspValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", rspValid); end
        compared++;
        if (rspData !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_data: got %h expected 0000", rspData); end
        compared++;
        if (rspId !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_id: got %0d expected 0", rspId); end
        reqValid = 4'b1111;
        #1;
        compared++;
        if (reqReady !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_ready: got %b expected 0000", reqReady); end
        reqValid = '0;
        rst_n    = 1'b1;
    endtask

    task automatic test_round_robin();
        int expGrant[5] = '{0, 1, 2, 3, 0};
        logic [3:0] expReady;
        for (int i = 0; i < NUM_REQ; i++) setReq(i, 16'hAAAA, 16'h5555, 2'b01);
        rspReady = 1'b1;
        reqValid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            expReady = 4'b0001 << expGrant[k];
            compared++;
            if (reqReady !== expReady) begin mismatched++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", k, reqReady, expReady); end
            tick();
            compared++;
            if (rspValid !== 1'b1) begin mismatched++; $display("[TB] FAIL rr_valid[%0d]: got %b expected 1", k, rspValid); end
            compared++;
            if (rspId !== 2'(expGrant[k])) begin mismatched++; $display("[TB] FAIL rr_id[%0d]: got %0d expected %0d", k, rspId, expGrant[k]); end
            compared++;
            if (rspData !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL rr_data[%0d]: got %h expected FFFF", k, rspData); end
        end
        reqValid = '0;
        #1;
        compared++;
        if (reqReady !== 4'b0000) begin mismatched++; $display("[TB] FAIL rr_idle_ready: got %b expected 0000", reqReady); end
        tick();
        compared++;
        if (rspValid !== 1'b0) begin mismatched++; $display("[TB] FAIL rr_drain_valid: got %b expected 0", rspValid); end
        compared++;
        if (rspData !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL rr_hold_data: got %h expected FFFF", rspData); end
    endtask

    task automatic test_single();
        setReq(1, 16'h3CC3, 16'h0FF0, 2'b00);
        rspReady = 1'b1;
        reqValid = 4'b0010;
        #1;
        compared++;
        if (reqReady !== 4'b0010) begin mismatched++; $display("[TB] FAIL single_ready: got %b expected 0010", reqReady); end
        tick();
        reqValid = '0;
        compared++;
        if (rspValid !== 1'b1) begin mismatched++; $display("[TB] FAIL single_valid: got %b expected 1", rspValid); end
        compared++;
        if (rspData !== 16'h0CC0) begin mismatched++; $display("[TB] FAIL single_data: got %h expected 0CC0", rspData); end
        compared++;
        if (rspId !== 2'd1) begin mismatched++; $display("[TB] FAIL single_id: got %0d expected 1", rspId); end
        tick();
        compared++;
        if (rspValid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_drain: got %b expected 0", rspValid); end
        compared++;
        if (rspId !== 2'd1) begin mismatched++; $display("[TB] FAIL single_hold_id: got %0d expected 1", rspId); end
    endtask

    task automatic test_backpressure();
        setReq(2, 16'h1234, 16'h9876, 2'b10);
        rspReady = 1'b0;
        reqValid = 4'b0100;
        #1;
        compared++;
        if (reqReady !== 4'b0100) begin mismatched++; $display("[TB] FAIL bp_first_ready: got %b expected 0100", reqReady); end
        tick();
        compared++;
        if (rspData !== 16'h8A42) begin mismatched++; $display("[TB] FAIL bp_data: got %h expected 8A42", rspData); end
        compared++;
        if (rspId !== 2'd2) begin mismatched++; $display("[TB] FAIL bp_id: got %0d expected 2", rspId); end
        setReq(0, 16'hF0F0, 16'hFF00, 2'b00);
        reqValid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            compared++;
            if (reqReady !== 4'b0000) begin mismatched++; $display("[TB] FAIL bp_stall_ready[%0d]: got %b expected 0000", c, reqReady); end
            tick();
            compared++;
            if (rspValid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_stall_valid[%0d]: got %b expected 1", c, rspValid); end
            compared++;
            if (rspData !== 16'h8A42) begin mismatched++; $display("[TB] FAIL bp_stall_data[%0d]: got %h expected 8A42", c, rspData); end
        end
        rspReady = 1'b1;
        #1;
        compared++;
        if (reqReady !== 4'b0001) begin mismatched++; $display("[TB] FAIL bp_release_ready: got %b expected 0001", reqReady); end
        tick();
        reqValid = '0;
        compared++;
        if (rspData !== 16'hF000) begin mismatched++; $display("[TB] FAIL bp_next_data: got %h expected F000", rspData); end
        compared++;
        if (rspId !== 2'd0) begin mismatched++; $display("[TB] FAIL bp_next_id: got %0d expected 0", rspId); end
        tick();
    endtask

    task automatic test_nand();
        setReq(3, 16'hFFFF, 16'hFFFF, 2'b11);
        rspReady = 1'b1;
        reqValid = 4'b1000;
        #1;
        compared++;
        if (reqReady !== 4'b1000) begin mismatched++; $display("[TB] FAIL nand_ready: got %b expected 1000", reqReady); end
        tick();
        compared++;
        if (rspData !== 16'h0000) begin mismatched++; $display("[TB] FAIL nand_ones: got %h expected 0000", rspData); end
        compared++;
        if (rspId !== 2'd3) begin mismatched++; $display("[TB] FAIL nand_id: got %0d expected 3", rspId); end
        setReq(3, 16'h0000, 16'hFFFF, 2'b11);
        tick();
        reqValid = '0;
        compared++;
        if (rspData !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL nand_zero: got %h expected FFFF", rspData); end
        compared++;
        if (rspValid !== 1'b1) begin mismatched++; $display("[TB] FAIL nand_valid: got %b expected 1", rspValid); end
        tick();
    endtask

    task automatic test_reset_mid();
        setReq(1, 16'h3CC3, 16'h0FF0, 2'b00);
        rspReady = 1'b0;
        reqValid = 4'b0010;
        tick();
        compared++;
        if (rspData !== 16'h0CC0) begin mismatched++; $display("[TB] FAIL mid_pre_data: got %h expected 0CC0", rspData); end
        reqValid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (rspValid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_valid: got %b expected 0", rspValid); end
        compared++;
        if (rspData !== 16'h0000) begin mismatched++; $display("[TB] FAIL mid_data: got %h expected 0000", rspData); end
        compared++;
        if (rspId !== 2'd0) begin mismatched++; $display("[TB] FAIL mid_id: got %0d expected 0", rspId); end
        compared++;
        if (reqReady !== 4'b0000) begin mismatched++; $display("[TB] FAIL mid_ready: got %b expected 0000", reqReady); end
        #2;
        rst_n    = 1'b1;
        rspReady = 1'b1;
        #1;
        compared++;
        if (reqReady !== 4'b0001) begin mismatched++; $display("[TB] FAIL mid_ptr_ready: got %b expected 0001", reqReady); end
        tick();
        reqValid = '0;
        compared++;
        if (rspId !== 2'd0) begin mismatched++; $display("[TB] FAIL mid_ptr_id: got %0d expected 0", rspId); end
        compared++;
        if (rspData !== 16'hF000) begin mismatched++; $display("[TB] FAIL mid_ptr_data: got %h expected F000", rspData); end
        tick();
    endtask

`ifdef BITOP16_ARB_LOCK_EN
    task automatic test_lock();
        int   expGrant[7] = '{1, 2, 3, 3, 3, 3, 0};
        logic lockBit[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < NUM_REQ; i++) setReq(i, 16'hAAAA, 16'h5555, 2'b01);
        rspReady = 1'b1;
        reqValid = 4'b1111;
        for (int k = 0; k < 7; k++) begin
            reqLock = {lockBit[k], 3'b000};
            tick();
            compared++;
            if (rspId !== 2'(expGrant[k])) begin mismatched++; $display("[TB] FAIL lock_id[%0d]: got %0d expected %0d", k, rspId, expGrant[k]); end
        end
        reqValid = '0;
        reqLock  = '0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_nand();
        test_reset_mid();
`ifdef BITOP16_ARB_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
